// File: rtl/protect_window_multi_if.sv
// -----------------------------------------------------------------------------
// protect_window_multi_if
// Bundles the fault-pin / PWM-enable signals of protect_window_multi.
//   ResetD    : operator fault clear (level, synchronous to CLK_50M)
//   ProTect   : per-channel active-low fault inputs (asynchronous)
//   PWMEN     : per-channel PWM enable, 1 = run
//   Trip_flag : per-channel, 1 while the channel is tripped
//   Lock_flag : per-channel, 1 while the channel is permanently locked
// master = controller/bench side, slave = protector side.
// -----------------------------------------------------------------------------
interface protect_window_multi_if #(
   parameter int N_CH = 4
);
   logic            ResetD;
   logic [N_CH-1:0] ProTect;
   logic [N_CH-1:0] PWMEN;
   logic [N_CH-1:0] Trip_flag;
   logic [N_CH-1:0] Lock_flag;

   modport master (
      output ResetD,
      output ProTect,
      input  PWMEN,
      input  Trip_flag,
      input  Lock_flag
   );

   modport slave (
      input  ResetD,
      input  ProTect,
      output PWMEN,
      output Trip_flag,
      output Lock_flag
   );
endinterface

// File: rtl/protect_window_multi.sv
// -----------------------------------------------------------------------------
// protect_window_multi
// Multi-channel bus short-circuit protector. Each channel counts falling edges
// of its active-low ProTect pin inside a fixed observation window and removes
// its PWM enable once FAULT_LIMIT edges fall in one window. A trip is either
// latched until ResetD or auto-released after HOLD_CYCLES, with at most
// MAX_RETRY auto-releases before a permanent lock. GLOBAL_TRIP=1 makes any
// faulted channel disable every channel.
// Ports:
//   CLK_50M : system clock, rising edge
//   Rst_n   : asynchronous active-low reset
//   bus     : protect_window_multi_if slave (ResetD, ProTect, PWMEN,
//             Trip_flag, Lock_flag)
// -----------------------------------------------------------------------------
module protect_window_multi #(
   parameter int N_CH        = 4,
   parameter int WIN_CYCLES  = 1000000,
   parameter int FAULT_LIMIT = 10,
   parameter int AUTO_RETRY  = 0,
   parameter int HOLD_CYCLES = 5000000,
   parameter int MAX_RETRY   = 3,
   parameter int GLOBAL_TRIP = 0
) (
   input  logic                   CLK_50M,
   input  logic                   Rst_n,
   protect_window_multi_if.slave  bus
);

   localparam int WW = (WIN_CYCLES  > 1) ? $clog2(WIN_CYCLES)  : 1;
   localparam int EW = $clog2(FAULT_LIMIT + 1);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int RW = (MAX_RETRY   > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_CYCLES - 1);
   localparam logic [EW-1:0] EDGE_LAST = EW'(FAULT_LIMIT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WIN  = 2'd1;
   localparam logic [1:0] S_TRIP = 2'd2;
   localparam logic [1:0] S_LOCK = 2'd3;

   logic [N_CH-1:0] w_local_en;
   logic [N_CH-1:0] w_trip;
   logic [N_CH-1:0] w_lock;
   logic            w_any_fault;

   logic [N_CH-1:0] r_pwmen;
   logic [N_CH-1:0] r_trip_flag;
   logic [N_CH-1:0] r_lock_flag;

   genvar gi;
   for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic          r_s1, r_s2, r_s3;
      logic [1:0]    r_state;
      logic [WW-1:0] r_wcnt;
      logic [EW-1:0] r_ecnt;
      logic [HW-1:0] r_hcnt;
      logic [RW-1:0] r_rcnt;
      logic          w_edge;

      // s3 is the history of s2, so this is a one-cycle high-to-low pulse.
      assign w_edge = r_s3 & ~r_s2;

      always_ff @(posedge CLK_50M or negedge Rst_n) begin
         if (!Rst_n) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_s3    <= 1'b1;
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_ecnt  <= '0;
            r_hcnt  <= '0;
            r_rcnt  <= '0;
         end else begin
            r_s1 <= bus.ProTect[gi];
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            case (r_state)
               S_IDLE: begin
                  if (w_edge) begin
                     if (FAULT_LIMIT == 1) begin
                        r_state <= S_TRIP;
                        r_hcnt  <= '0;
                     end else begin
                        r_state <= S_WIN;
                        r_wcnt  <= '0;
                        r_ecnt  <= EW'(1);
                     end
                  end
               end

               S_WIN: begin
                  // Trip is tested first so an edge on the expiry cycle still counts.
                  if (w_edge && (r_ecnt == EDGE_LAST)) begin
                     r_state <= S_TRIP;
                     r_wcnt  <= '0;
                     r_ecnt  <= '0;
                     r_hcnt  <= '0;
                  end else if (r_wcnt == WIN_LAST) begin
                     // A quiet window means the fault has gone away: forget retries.
                     r_state <= S_IDLE;
                     r_wcnt  <= '0;
                     r_ecnt  <= '0;
                     r_rcnt  <= '0;
                  end else begin
                     r_wcnt <= r_wcnt + 1'b1;
                     if (w_edge) begin
                        r_ecnt <= r_ecnt + 1'b1;
                     end
                  end
               end

               S_TRIP: begin
                  if (bus.ResetD) begin
                     r_state <= S_IDLE;
                     r_wcnt  <= '0;
                     r_ecnt  <= '0;
                     r_hcnt  <= '0;
                     r_rcnt  <= '0;
                  end else if (AUTO_RETRY != 0) begin
                     if (r_hcnt == HOLD_LAST) begin
                        r_hcnt <= '0;
                        if (r_rcnt == RETRY_MAX) begin
                           r_state <= S_LOCK;
                        end else begin
                           r_state <= S_IDLE;
                           r_rcnt  <= r_rcnt + 1'b1;
                        end
                     end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                     end
                  end
               end

               default: begin
                  // LOCK: only the operator clear gets the channel back.
                  if (bus.ResetD) begin
                     r_state <= S_IDLE;
                     r_wcnt  <= '0;
                     r_ecnt  <= '0;
                     r_hcnt  <= '0;
                     r_rcnt  <= '0;
                  end
               end
            endcase
         end
      end

      assign w_local_en[gi] = (r_state == S_IDLE) || (r_state == S_WIN);
      assign w_trip[gi]     = (r_state == S_TRIP);
      assign w_lock[gi]     = (r_state == S_LOCK);
   end

   assign w_any_fault = |(w_trip | w_lock);

   always_ff @(posedge CLK_50M or negedge Rst_n) begin
      if (!Rst_n) begin
         r_pwmen     <= '1;
         r_trip_flag <= '0;
         r_lock_flag <= '0;
      end else begin
         if (GLOBAL_TRIP != 0) begin
            r_pwmen <= w_local_en & {N_CH{~w_any_fault}};
         end else begin
            r_pwmen <= w_local_en;
         end
         r_trip_flag <= w_trip;
         r_lock_flag <= w_lock;
      end
   end

   assign bus.PWMEN     = r_pwmen;
   assign bus.Trip_flag = r_trip_flag;
   assign bus.Lock_flag = r_lock_flag;

endmodule

// File: tb/tb_protect_window_multi.sv
// -----------------------------------------------------------------------------
// tb_protect_window_multi
// Four protector instances with different parameter sets share one clock and
// reset: A = defaults, B = short window (100) / limit 3, C = auto-retry
// (hold 50, two retries), D = global trip. Expected outputs are hand-derived.
// -----------------------------------------------------------------------------
module tb_protect_window_multi;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   protect_window_multi_if #(.N_CH(4)) ifa();
   protect_window_multi_if #(.N_CH(4)) ifb();
   protect_window_multi_if #(.N_CH(4)) ifc();
   protect_window_multi_if #(.N_CH(4)) ifd();

   protect_window_multi #(.N_CH(4)) u_a (
      .CLK_50M (clk),
      .Rst_n   (rst_n),
      .bus     (ifa)
   );

   protect_window_multi #(.N_CH(4), .WIN_CYCLES(100), .FAULT_LIMIT(3)) u_b (
      .CLK_50M (clk),
      .Rst_n   (rst_n),
      .bus     (ifb)
   );

   protect_window_multi #(.N_CH(4), .WIN_CYCLES(1000), .FAULT_LIMIT(3),
                          .AUTO_RETRY(1), .HOLD_CYCLES(50), .MAX_RETRY(2)) u_c (
      .CLK_50M (clk),
      .Rst_n   (rst_n),
      .bus     (ifc)
   );

   protect_window_multi #(.N_CH(4), .WIN_CYCLES(1000), .FAULT_LIMIT(3),
                          .GLOBAL_TRIP(1)) u_d (
      .CLK_50M (clk),
      .Rst_n   (rst_n),
      .bus     (ifd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         d;
      logic [1:0] ch;
      int         n;
      logic       rd;
      logic [3:0] pw;
      logic [3:0] tr;
      logic [3:0] lk;
   } vec_t;

   vec_t tbl[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pt(input int d, input logic [1:0] ch, input logic v);
      case (d)
         0:       ifa.ProTect[ch] = v;
         1:       ifb.ProTect[ch] = v;
         2:       ifc.ProTect[ch] = v;
         default: ifd.ProTect[ch] = v;
      endcase
   endtask

   task automatic set_rd(input int d, input logic v);
      case (d)
         0:       ifa.ResetD = v;
         1:       ifb.ResetD = v;
         2:       ifc.ResetD = v;
         default: ifd.ResetD = v;
      endcase
   endtask

   // n falling edges, each 4 cycles low then 4 cycles high
   task automatic edges(input int d, input logic [1:0] ch, input int n);
      for (int i = 0; i < n; i++) begin
         set_pt(d, ch, 1'b0);
         repeat (4) tick();
         set_pt(d, ch, 1'b1);
         repeat (4) tick();
      end
   endtask

   task automatic rd_pulse(input int d);
      set_rd(d, 1'b1);
      tick();
      set_rd(d, 1'b0);
      tick();
   endtask

   task automatic check(input string nm, input int d,
                        input logic [3:0] epw, input logic [3:0] etr,
                        input logic [3:0] elk);
      logic [3:0] pw, tr, lk;
      case (d)
         0:       begin pw = ifa.PWMEN; tr = ifa.Trip_flag; lk = ifa.Lock_flag; end
         1:       begin pw = ifb.PWMEN; tr = ifb.Trip_flag; lk = ifb.Lock_flag; end
         2:       begin pw = ifc.PWMEN; tr = ifc.Trip_flag; lk = ifc.Lock_flag; end
         default: begin pw = ifd.PWMEN; tr = ifd.Trip_flag; lk = ifd.Lock_flag; end
      endcase
      n_checks++;
      if ({pw, tr, lk} !== {epw, etr, elk}) begin
         n_fail++;
         $display("FAIL %s: PWMEN=%b Trip=%b Lock=%b, expected PWMEN=%b Trip=%b Lock=%b",
                  nm, pw, tr, lk, epw, etr, elk);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;

      tbl[0] = '{0, 2'd1,  9, 1'b0, 4'b1111, 4'b0000, 4'b0000};
      tbl[1] = '{0, 2'd1,  1, 1'b0, 4'b1101, 4'b0010, 4'b0000};
      tbl[2] = '{0, 2'd3, 10, 1'b0, 4'b0101, 4'b1010, 4'b0000};
      tbl[3] = '{0, 2'd3,  5, 1'b0, 4'b0101, 4'b1010, 4'b0000};
      tbl[4] = '{0, 2'd0,  0, 1'b1, 4'b1111, 4'b0000, 4'b0000};
      tbl[5] = '{1, 2'd1,  3, 1'b0, 4'b1101, 4'b0010, 4'b0000};
      tbl[6] = '{1, 2'd0,  0, 1'b1, 4'b1111, 4'b0000, 4'b0000};
      tbl[7] = '{3, 2'd0,  2, 1'b0, 4'b1111, 4'b0000, 4'b0000};
      tbl[8] = '{3, 2'd0,  1, 1'b0, 4'b0000, 4'b0001, 4'b0000};
      tbl[9] = '{3, 2'd0,  0, 1'b1, 4'b1111, 4'b0000, 4'b0000};

      rst_n = 1'b0;
      ifa.ProTect = '1; ifb.ProTect = '1; ifc.ProTect = '1; ifd.ProTect = '1;
      ifa.ResetD  = 1'b0; ifb.ResetD = 1'b0; ifc.ResetD = 1'b0; ifd.ResetD = 1'b0;

      repeat (3) tick();
      check("reset_a", 0, 4'b1111, 4'b0000, 4'b0000);
      check("reset_c", 2, 4'b1111, 4'b0000, 4'b0000);
      rst_n = 1'b1;
      repeat (2) tick();
      check("post_reset_d", 3, 4'b1111, 4'b0000, 4'b0000);

      // A ch0: trip latency and ResetD release latency
      edges(0, 2'd0, 9);
      set_pt(0, 2'd0, 1'b0);
      tick();                                   // edge k
      tick();                                   // k+1
      tick();                                   // k+2
      check("trip_k2_not_yet", 0, 4'b1111, 4'b0000, 4'b0000);
      tick();                                   // k+3
      check("trip_k3", 0, 4'b1110, 4'b0001, 4'b0000);
      repeat (3) tick();
      set_pt(0, 2'd0, 1'b1);
      repeat (4) tick();
      set_rd(0, 1'b1);
      tick();                                   // edge m
      check("resetd_m", 0, 4'b1110, 4'b0001, 4'b0000);
      set_rd(0, 1'b0);
      tick();                                   // m+1
      check("resetd_m1", 0, 4'b1111, 4'b0000, 4'b0000);

      for (int v = 0; v < 10; v++) begin
         if (tbl[v].n > 0) edges(tbl[v].d, tbl[v].ch, tbl[v].n);
         if (tbl[v].rd) rd_pulse(tbl[v].d);
         repeat (4) tick();
         check($sformatf("vec%0d", v), tbl[v].d, tbl[v].pw, tbl[v].tr, tbl[v].lk);
      end

      // A ch1: a held-low pin counts once; ResetD held during WIN is ignored
      set_pt(0, 2'd1, 1'b0);
      repeat (200) tick();
      check("held_low", 0, 4'b1111, 4'b0000, 4'b0000);
      set_pt(0, 2'd1, 1'b1);
      repeat (4) tick();
      set_rd(0, 1'b1);
      edges(0, 2'd1, 8);
      check("resetd_in_win", 0, 4'b1111, 4'b0000, 4'b0000);
      set_rd(0, 1'b0);
      edges(0, 2'd1, 1);
      check("held_low_tenth", 0, 4'b1101, 4'b0010, 4'b0000);
      rd_pulse(0);
      check("held_low_clear", 0, 4'b1111, 4'b0000, 4'b0000);

      // B ch0: third edge one cycle after the expiry cycle opens a new window
      set_pt(1, 2'd0, 1'b0); tick();            // k1
      repeat (3) tick(); set_pt(1, 2'd0, 1'b1); repeat (4) tick();
      set_pt(1, 2'd0, 1'b0); tick();            // k1+8
      repeat (3) tick(); set_pt(1, 2'd0, 1'b1);
      repeat (89) tick();
      set_pt(1, 2'd0, 1'b0); tick();            // k1+101
      repeat (3) tick();
      check("late_edge_no_trip", 1, 4'b1111, 4'b0000, 4'b0000);
      set_pt(1, 2'd0, 1'b1); repeat (4) tick();
      edges(1, 2'd0, 1);
      check("new_window_2", 1, 4'b1111, 4'b0000, 4'b0000);
      edges(1, 2'd0, 1);
      check("new_window_3", 1, 4'b1110, 4'b0001, 4'b0000);
      rd_pulse(1);

      // B ch0: third edge on the expiry cycle still trips
      set_pt(1, 2'd0, 1'b0); tick();            // k1
      repeat (3) tick(); set_pt(1, 2'd0, 1'b1); repeat (4) tick();
      set_pt(1, 2'd0, 1'b0); tick();            // k1+8
      repeat (3) tick(); set_pt(1, 2'd0, 1'b1);
      repeat (88) tick();
      set_pt(1, 2'd0, 1'b0); tick();            // k1+100
      repeat (3) tick();
      check("expiry_edge_trip", 1, 4'b1110, 4'b0001, 4'b0000);
      set_pt(1, 2'd0, 1'b1); tick();
      rd_pulse(1);
      check("expiry_clear", 1, 4'b1111, 4'b0000, 4'b0000);

      // C ch0: two auto-releases 50 cycles after each trip, then LOCK
      for (int b = 0; b < 3; b++) begin
         edges(2, 2'd0, 2);
         set_pt(2, 2'd0, 1'b0); tick();          // k3
         repeat (3) tick(); set_pt(2, 2'd0, 1'b1);
         repeat (49) tick();                     // k3+52
         check($sformatf("hold_%0d", b), 2, 4'b1110, 4'b0001, 4'b0000);
         tick();                                 // k3+53
         if (b < 2) check($sformatf("release_%0d", b), 2, 4'b1111, 4'b0000, 4'b0000);
         else       check("lock_entry", 2, 4'b1110, 4'b0000, 4'b0001);
      end
      repeat (100) tick();
      check("lock_stays", 2, 4'b1110, 4'b0000, 4'b0001);
      rd_pulse(2);
      check("lock_clear", 2, 4'b1111, 4'b0000, 4'b0000);

      // D ch2: global trip drops every enable on the same edge as Trip_flag
      edges(3, 2'd2, 2);
      set_pt(3, 2'd2, 1'b0); tick();            // k3
      tick(); tick();                           // k3+2
      check("global_k2", 3, 4'b1111, 4'b0000, 4'b0000);
      tick();                                   // k3+3
      check("global_k3", 3, 4'b0000, 4'b0100, 4'b0000);
      repeat (3) tick(); set_pt(3, 2'd2, 1'b1); repeat (4) tick();
      rd_pulse(3);
      check("global_clear", 3, 4'b1111, 4'b0000, 4'b0000);

      // A ch0: asynchronous reset while tripped
      edges(0, 2'd0, 10);
      check("pre_async", 0, 4'b1110, 4'b0001, 4'b0000);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", 0, 4'b1111, 4'b0000, 4'b0000);
      #10;
      rst_n = 1'b1;
      repeat (2) tick();
      edges(0, 2'd0, 9);
      check("after_reset_no_memory", 0, 4'b1111, 4'b0000, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/protect_window_multi.md
# protect_window_multi

Multi-channel successor to the single-channel bus short-circuit protector. For each of N_CH active-low protect inputs, it counts falling edges inside a fixed observation window and drops that channel's PWM enable once FAULT_LIMIT edges land in one window. Trip release is either latched until ResetD, or automatic after a hold time with a bounded retry count, and an optional global-trip mode disables all channels together. It sits between the comparator/driver fault pins and the PWM generator enables.

## Interface
- N_CH, 4: number of independent protect channels (≥1)
- WIN_CYCLES, 1000000: observation window length in clock cycles (20 ms at 50 MHz)
- FAULT_LIMIT, 10: falling edges within one window that cause a trip (≥1)
- AUTO_RETRY, 0: 0 = trip latched until ResetD; 1 = auto-release after HOLD_CYCLES
- HOLD_CYCLES, 5000000: auto-release hold time in cycles (used when AUTO_RETRY=1)
- MAX_RETRY, 3: auto-releases allowed before permanent lock (used when AUTO_RETRY=1)
- GLOBAL_TRIP, 0: 1 = any tripped or locked channel forces every PWMEN bit low
- CLK_50M  in  1  system clock, all logic on rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- ResetD  in  1  synchronous level, operator fault clear
- ProTect  in  N_CH  per-channel protect, active-low fault, asynchronous to CLK_50M
- PWMEN  out  N_CH  per-channel PWM enable, 1 = run
- Trip_flag  out  N_CH  1 while channel in TRIP
- Lock_flag  out  N_CH  1 while channel in LOCK

## Operation
- Per channel: 2-flop synchroniser (s1, s2), plus history flop s3. Edge pulse e = s3 & ~s2. Synchroniser flops reset to 1.
- Counters per channel: window counter wcnt, width $clog2(WIN_CYCLES); edge counter ecnt, width $clog2(FAULT_LIMIT+1), saturating; hold counter hcnt; retry counter rcnt, saturating at MAX_RETRY.
- States per channel: IDLE, WIN, TRIP, LOCK.
- IDLE: on e, go to WIN with wcnt=0 and ecnt=1. If FAULT_LIMIT==1, go directly to TRIP instead.
- WIN: wcnt increments every cycle, and ecnt increments on e.
  - Trip when e occurs and ecnt+1 == FAULT_LIMIT: go to TRIP, clear wcnt, ecnt, hcnt.
  - Otherwise, when wcnt == WIN_CYCLES-1, the window expires: go to IDLE, clear ecnt, clear rcnt.
  - Trip and expiry on the same cycle: trip wins.
- TRIP:
  - ResetD=1: go to IDLE, clear all counters including rcnt. ResetD has priority over the hold timeout.
  - AUTO_RETRY=1 and hcnt == HOLD_CYCLES-1: if rcnt == MAX_RETRY go to LOCK, else go to IDLE and increment rcnt.
  - AUTO_RETRY=0: stays in TRIP until ResetD.
- LOCK: exits only on ResetD=1, to IDLE with all counters cleared.
- ResetD in IDLE or WIN: ignored. The window keeps running.
- Edges arriving in TRIP or LOCK are ignored. ProTect held low does not retrigger, since only falling edges count.
- Local enable: local_en[i] = state in IDLE or WIN.
- GLOBAL_TRIP=0: PWMEN[i] = local_en[i].
- GLOBAL_TRIP=1: PWMEN[i] = local_en[i] & ~(any channel in TRIP or LOCK).
- PWMEN, Trip_flag, and Lock_flag are registered outputs.

## Timing
- Reset (Rst_n low, asynchronous): all states IDLE, counters 0, s1/s2/s3 = 1. PWMEN = all 1, Trip_flag = 0, Lock_flag = 0.
- Trip latency: the limiting ProTect low is first sampled into s1 at edge k. The state becomes TRIP at edge k+2. PWMEN goes low and Trip_flag goes high at edge k+3.
- Minimum detectable pulse: ProTect low and high each held ≥2 clock cycles.
- Window timing: the window spans WIN_CYCLES cycles counted from the state register update that entered WIN. An edge detected on the expiry cycle still counts (trip wins).
- Release timing: ResetD high sampled at edge m. State becomes IDLE at m. PWMEN rises and flags clear at m+1.
- Auto-release timing: TRIP is entered at edge t. The exit transition happens at edge t+HOLD_CYCLES. PWMEN rises at t+HOLD_CYCLES+1.
- Channels are fully independent, except for the GLOBAL_TRIP combine.
- Rst_n asserted mid-window or mid-trip: immediate return to reset values. No memory of prior faults survives.

## Test plan
- Defaults, ch0: 10 falling edges (4 cycles low / 4 high) inside the window → PWMEN[0] low 3 edges after the 10th low is sampled; Trip_flag[0]=1; other channels unaffected. ResetD 1 cycle → PWMEN[0]=1 next edge.
- WIN_CYCLES=100, FAULT_LIMIT=3: 2 edges, then 3rd edge after window expiry → no trip; new window opens with ecnt=1. 3rd edge on the expiry cycle → trip.
- AUTO_RETRY=1, HOLD_CYCLES=50, MAX_RETRY=2, repeated fault bursts → two auto-releases 50 cycles after each trip; third trip → LOCK, Lock_flag=1, PWMEN stays 0 until ResetD.
- GLOBAL_TRIP=1, N_CH=4: trip ch2 → PWMEN=4'b0000 on the same edge Trip_flag[2] rises; ResetD → 4'b1111.
- ProTect[1] held low continuously → exactly one edge counted, no trip. ResetD held high during WIN → window unaffected.
- Rst_n pulsed low asynchronously while ch0 is in TRIP → PWMEN=all 1 and flags 0 immediately, without waiting for a clock edge.
